change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/maquina_pkg.sv | 30 +++
 rtl/coin_timer.sv | 26 ++
 rtl/change_dispenser.sv | 173 +++++++++++++++++
 tb/tb_change_dispenser.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// rtl/maquina_pkg.sv - shared states, coin values and amount legality check for the change dispenser
package maquina_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_20   = 2'd1,
        COIN_10   = 2'd2,
        COIN_5    = 2'd3
    } coin_t;

    localparam logic [6:0] COIN_5_VAL  = 7'd5;
    localparam logic [6:0] COIN_10_VAL = 7'd10;
    localparam logic [6:0] COIN_20_VAL = 7'd20;
    localparam logic [6:0] MAX_AMOUNT  = 7'd100;

    // Payable amounts are whole nickels up to the machine maximum.
    function automatic logic is_legal_amount(input logic [6:0] amt);
        return (amt <= MAX_AMOUNT) && ((amt % COIN_5_VAL) == 7'd0);
    endfunction

endpackage

// File: rtl/coin_timer.sv
// rtl/coin_timer.sv - loadable down-counter timing both eject pulses and inter-coin gaps
module coin_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change dispenser with timed eject pulses and reloadable inventory
module change_dispenser
    import maquina_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       load,
    input  logic [3:0] inv20_in,
    input  logic [3:0] inv10_in,
    input  logic [3:0] inv5_in,
    output logic       d20,
    output logic       d10,
    output logic       d5,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] inv20,
    output logic [3:0] inv10,
    output logic [3:0] inv5
);

    localparam int TIMER_W = 8;
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    state_t state, state_next;
    coin_t  coin_sel, coin_next;

    logic [6:0] remaining;
    logic [6:0] coin_val;
    logic [6:0] req_amt;
    logic [6:0] pend_amount;
    logic       pend;
    logic       accept;
    logic       take_coin;
    logic       do_load;
    logic       timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic       timer_tc;

    coin_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start that arrives with a load is parked for one cycle so it sees the new inventory.
    assign req_amt = pend ? pend_amount : amount;

    always_comb begin
        state_next = state;
        coin_next  = COIN_NONE;
        coin_val   = 7'd0;
        accept     = 1'b0;
        take_coin  = 1'b0;
        do_load    = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_IDLE: begin
                if (!pend && load) begin
                    do_load = 1'b1;
                end else if (pend || start) begin
                    if (req_amt == 7'd0) begin
                        state_next = ST_DONE;
                    end else if (!is_legal_amount(req_amt)) begin
                        state_next = ST_ERROR;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                if (remaining == 7'd0) begin
                    state_next = ST_DONE;
                end else begin
                    if (remaining >= COIN_20_VAL && inv20 != 4'd0) begin
                        coin_next = COIN_20;
                        coin_val  = COIN_20_VAL;
                    end else if (remaining >= COIN_10_VAL && inv10 != 4'd0) begin
                        coin_next = COIN_10;
                        coin_val  = COIN_10_VAL;
                    end else if (inv5 != 4'd0) begin
                        coin_next = COIN_5;
                        coin_val  = COIN_5_VAL;
                    end
                    if (coin_next == COIN_NONE) begin
                        state_next = ST_ERROR;
                    end else begin
                        take_coin  = 1'b1;
                        timer_load = 1'b1;
                        timer_val  = PULSE_LOAD;
                        state_next = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (timer_tc) begin
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_tc) begin
                    state_next = ST_SELECT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining   <= 7'd0;
            inv20       <= 4'd0;
            inv10       <= 4'd0;
            inv5        <= 4'd0;
            coin_sel    <= COIN_NONE;
            pend        <= 1'b0;
            pend_amount <= 7'd0;
        end else begin
            pend <= do_load && start;
            if (do_load) begin
                inv20       <= inv20_in;
                inv10       <= inv10_in;
                inv5        <= inv5_in;
                pend_amount <= amount;
            end
            if (accept) begin
                remaining <= req_amt;
            end else if (take_coin) begin
                remaining <= remaining - coin_val;
                coin_sel  <= coin_next;
                case (coin_next)
                    COIN_20: inv20 <= inv20 - 4'd1;
                    COIN_10: inv10 <= inv10 - 4'd1;
                    COIN_5:  inv5  <= inv5 - 4'd1;
                    default: ;
                endcase
            end else if (state == ST_ERROR) begin
                remaining <= 7'd0;
            end
        end
    end

    // Outputs decode straight from state so reset silences them without waiting for a clock.
    assign d20  = (state == ST_PULSE) && (coin_sel == COIN_20);
    assign d10  = (state == ST_PULSE) && (coin_sel == COIN_10);
    assign d5   = (state == ST_PULSE) && (coin_sel == COIN_5);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERROR);

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser against a greedy change model
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 2;

    localparam logic [5:0] V_IDLE = 6'b000000;
    localparam logic [5:0] V_BUSY = 6'b000100;
    localparam logic [5:0] V_D20  = 6'b100100;
    localparam logic [5:0] V_D10  = 6'b010100;
    localparam logic [5:0] V_D5   = 6'b001100;
    localparam logic [5:0] V_DONE = 6'b000110;
    localparam logic [5:0] V_ERR  = 6'b000101;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] amount;
    logic       load;
    logic [3:0] inv20_in, inv10_in, inv5_in;
    logic       d20, d10, d5, busy, done, err;
    logic [3:0] inv20, inv10, inv5;

    int n_checks = 0;
    int n_fail   = 0;
    int mi20 = 0, mi10 = 0, mi5 = 0;
    logic [5:0] exp_q[$];

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .amount   (amount),
        .load     (load),
        .inv20_in (inv20_in),
        .inv10_in (inv10_in),
        .inv5_in  (inv5_in),
        .d20      (d20),
        .d10      (d10),
        .d5       (d5),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .inv20    (inv20),
        .inv10    (inv10),
        .inv5     (inv5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] out_vec();
        return {d20, d10, d5, busy, done, err};
    endfunction

    task automatic check_inv(input string tag);
        check({tag, " inv"}, {20'd0, inv20, inv10, inv5},
              {20'd0, 4'(mi20), 4'(mi10), 4'(mi5)});
    endtask

    // Expected output trace for one request, derived from the greedy paying rules.
    task automatic build_expected(input int amt, input bit pending);
        int rem;
        exp_q.delete();
        if (pending) exp_q.push_back(V_IDLE);
        if (amt == 0) begin
            exp_q.push_back(V_DONE);
        end else if (amt > 100 || (amt % 5) != 0) begin
            exp_q.push_back(V_ERR);
        end else begin
            rem = amt;
            exp_q.push_back(V_BUSY);
            forever begin
                logic [5:0] cv;
                if (rem == 0) begin
                    exp_q.push_back(V_DONE);
                    break;
                end
                if (rem >= 20 && mi20 > 0) begin
                    cv = V_D20; rem -= 20; mi20--;
                end else if (rem >= 10 && mi10 > 0) begin
                    cv = V_D10; rem -= 10; mi10--;
                end else if (mi5 > 0) begin
                    cv = V_D5; rem -= 5; mi5--;
                end else begin
                    exp_q.push_back(V_ERR);
                    break;
                end
                repeat (P) exp_q.push_back(cv);
                repeat (G) exp_q.push_back(V_BUSY);
                exp_q.push_back(V_BUSY);
            end
        end
    endtask

    task automatic do_load(input int l20, input int l10, input int l5);
        load = 1'b1;
        inv20_in = 4'(l20); inv10_in = 4'(l10); inv5_in = 4'(l5);
        @(negedge clk);
        load = 1'b0;
        mi20 = l20; mi10 = l10; mi5 = l5;
        check("load", {20'd0, inv20, inv10, inv5}, {20'd0, 4'(l20), 4'(l10), 4'(l5)});
    endtask

    // Called at a negedge; drives the request, then walks the expected trace one cycle at a time.
    task automatic run_request(input int amt, input bit with_load, input int l20, input int l10,
                               input int l5, input bit noise);
        start  = 1'b1;
        amount = 7'(amt);
        if (with_load) begin
            load = 1'b1;
            inv20_in = 4'(l20); inv10_in = 4'(l10); inv5_in = 4'(l5);
            mi20 = l20; mi10 = l10; mi5 = l5;
        end
        build_expected(amt, with_load);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("amt%0d cyc%0d", amt, i), {26'd0, out_vec()}, {26'd0, exp_q[i]});
            start = 1'b0;
            load  = 1'b0;
            if (noise && i < exp_q.size() - 1 && !(with_load && i == 0)) begin
                start    = 1'($urandom);
                load     = 1'($urandom);
                amount   = 7'($urandom);
                inv20_in = 4'($urandom);
                inv10_in = 4'($urandom);
                inv5_in  = 4'($urandom);
            end
        end
        start = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        check($sformatf("amt%0d idle", amt), {26'd0, out_vec()}, {26'd0, V_IDLE});
        check_inv($sformatf("amt%0d", amt));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; load = 1'b0; amount = 7'd0;
        inv20_in = 4'd0; inv10_in = 4'd0; inv5_in = 4'd0;
        repeat (2) @(negedge clk);
        check("reset outputs", {26'd0, out_vec()}, 32'd0);
        check_inv("reset");
        rst = 1'b1;

        // First start right after reset release, empty inventory.
        run_request(15, 1'b0, 0, 0, 0, 1'b0);

        do_load(3, 3, 3);
        run_request(35, 1'b0, 0, 0, 0, 1'b0);
        check_inv("after35");

        do_load(0, 1, 4);
        run_request(40, 1'b0, 0, 0, 0, 1'b0);

        run_request(0, 1'b0, 0, 0, 0, 1'b0);
        do_load(5, 5, 5);
        run_request(37, 1'b0, 0, 0, 0, 1'b0);
        run_request(105, 1'b0, 0, 0, 0, 1'b0);

        // Load and start on the same edge: start waits a cycle and uses the new counts.
        run_request(35, 1'b1, 1, 1, 1, 1'b0);
        run_request(60, 1'b0, 0, 0, 0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            int a;
            bit wl;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 127);
            else                           a = 5 * $urandom_range(0, 20);
            wl = ($urandom_range(0, 3) == 0);
            if (!wl && $urandom_range(0, 2) == 0)
                do_load($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            run_request(a, wl, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 8),
                        1'($urandom));
        end

        // Reset during the second eject pulse of a 30c request.
        do_load(3, 3, 3);
        start = 1'b1; amount = 7'd30;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("second pulse d10", {26'd0, out_vec()}, {26'd0, V_D10});
        #2 rst = 1'b0;
        #1;
        check("async reset outputs", {26'd0, out_vec()}, 32'd0);
        @(negedge clk);
        mi20 = 0; mi10 = 0; mi5 = 0;
        check("reset mid outputs", {26'd0, out_vec()}, 32'd0);
        check_inv("reset mid");
        rst = 1'b1;
        run_request(0, 1'b0, 0, 0, 0, 1'b0);
        run_request(20, 1'b0, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
